// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

  // Transmitter sequencing states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bit counter width: enough to hold 0..width-1, never narrower than one bit.
  function automatic int piso_cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry holding register between the word handshake and the shifter.
// A word is captured when the entry is empty; the shifter empties it with take.
module piso_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             take,
  output logic             buf_full,
  output logic [WIDTH-1:0] buf_data
);

  logic             full_reg;
  logic [WIDTH-1:0] data_reg;

  // Ready depends only on the stored flag, never on wr_valid.
  assign wr_ready = !full_reg;
  assign buf_full = full_reg;
  assign buf_data = data_reg;

  // Capture into an empty entry; take only happens while full, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (take) begin
      full_reg <= 1'b0;
    end else if (wr_valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= wr_data;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter. Words arrive over valid/ready into a
// one-entry buffer and leave one bit per shift_en tick on d_out, with frame
// marking payload bits. The buffer lets the next word follow with no gap.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             d_out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W    = piso_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  piso_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic             d_out_reg;
  logic             frame_reg;
  logic             done_reg;

  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             take;
  logic             last_bit;
  logic [WIDTH-1:0] shreg_next;
  logic             first_bit;
  logic             next_bit;

  piso_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (in_data),
    .take     (take),
    .buf_full (buf_full),
    .buf_data (buf_data)
  );

  assign last_bit = (cnt_reg == CNT_LAST);

  // A buffered word moves into the shifter on a tick, either from idle or
  // straight after the previous word's final bit interval.
  assign take = shift_en && buf_full &&
                ((state_reg == IDLE) || ((state_reg == SHIFT) && last_bit));

  // Shift direction and output bit selection follow the configured bit order.
  always_comb begin
    shreg_next = MSB_FIRST ? (shreg_reg << 1) : (shreg_reg >> 1);
    first_bit  = MSB_FIRST ? buf_data[WIDTH-1] : buf_data[0];
    next_bit   = MSB_FIRST ? shreg_next[WIDTH-1] : shreg_next[0];
  end

  // Sequencer: load, shift, and end-of-word handling with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
      d_out_reg <= IDLE_LEVEL;
      frame_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (take) begin
            shreg_reg <= buf_data;
            cnt_reg   <= '0;
            d_out_reg <= first_bit;
            frame_reg <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (!last_bit) begin
              cnt_reg   <= cnt_reg + CNT_W'(1);
              shreg_reg <= shreg_next;
              d_out_reg <= next_bit;
            end else begin
              done_reg <= 1'b1;
              if (buf_full) begin
                // Chain straight into the next word; frame stays asserted.
                shreg_reg <= buf_data;
                cnt_reg   <= '0;
                d_out_reg <= first_bit;
              end else begin
                cnt_reg   <= '0;
                d_out_reg <= IDLE_LEVEL;
                frame_reg <= 1'b0;
                state_reg <= IDLE;
              end
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign d_out = d_out_reg;
  assign frame = frame_reg;
  assign done  = done_reg;
  assign busy  = (state_reg == SHIFT) || buf_full;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: a cycle table for one word, plus
// streaming, slow-tick, backpressure, LSB-first and mid-word reset sequences.
module tb_piso_shift_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, shift_en, in_ready, d_out, frame, busy, done;
  logic [W-1:0] in_data;
  logic         in_valid_l, shift_en_l, in_ready_l, d_out_l, frame_l, busy_l, done_l;
  logic [W-1:0] in_data_l;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_en(shift_en), .d_out(d_out), .frame(frame), .busy(busy), .done(done)
  );

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data_l),
    .shift_en(shift_en_l), .d_out(d_out_l), .frame(frame_l), .busy(busy_l), .done(done_l)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  // {d_out, frame, done, busy, in_ready}
  function automatic logic [4:0] outs_m();
    return {d_out, frame, done, busy, in_ready};
  endfunction

  typedef struct {
    logic       se;
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[11];

  // Streaming collectors.
  logic [7:0]  words_g[4];
  int          acc_cyc[$];
  int          done_cyc[$];
  int          frame_cnt, first_frame, last_frame, viol, tick_n;
  logic [31:0] tick_val;

  task automatic stream(input int n_words, input int period, input int stall, input int ncyc);
    int   idx;
    logic acc;
    logic prev_d;
    logic se_now;
    idx = 0;
    acc_cyc.delete();
    done_cyc.delete();
    frame_cnt = 0; first_frame = -1; last_frame = -1; viol = 0; tick_n = 0; tick_val = '0;
    for (int c = 0; c < ncyc; c++) begin
      se_now   = (c >= stall) && (((c - stall) % period) == period - 1);
      shift_en = se_now;
      in_valid = (idx < n_words);
      in_data  = (idx < n_words) ? words_g[idx] : 8'h00;
      acc      = in_valid && in_ready;
      prev_d   = d_out;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc.push_back(c);
        idx++;
      end
      if (!se_now && (d_out !== prev_d)) viol++;
      if (frame) begin
        frame_cnt++;
        if (first_frame < 0) first_frame = c;
        last_frame = c;
        if (se_now) begin
          tick_val = {tick_val[30:0], d_out};
          tick_n++;
        end
      end
      if (done) done_cyc.push_back(c);
    end
    shift_en = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic lsb_word(input logic [7:0] w, input string tag);
    logic [7:0] got;
    logic       fr_all;
    fr_all = 1'b1;
    shift_en_l = 1'b1;
    in_valid_l = 1'b1;
    in_data_l  = w;
    @(posedge clk); #1;
    in_valid_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      got[k] = d_out_l;
      fr_all = fr_all & frame_l;
    end
    check({tag, "_bits"}, {24'h0, got}, {24'h0, w});
    check({tag, "_frame"}, {31'h0, fr_all}, 32'h1);
    @(posedge clk); #1;
    check({tag, "_done"}, {30'h0, done_l, frame_l}, 32'h2);
  endtask

  initial begin
    int seen_frame, seen_done, seen_busy;

    vecs[0]  = '{1'b1, 1'b1, 8'hA5, 5'b00010};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 5'b11011};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 5'b01011};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 5'b11011};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 5'b01011};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 5'b01011};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 5'b11011};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 5'b01011};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 5'b11011};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 5'b00101};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 5'b00001};

    // Reset with a word offered: it must be ignored.
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; shift_en = 1'b1;
    in_valid_l = 1'b0; in_data_l = '0; shift_en_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {27'h0, outs_m()}, 32'h01);
    check("reset_outs_lsb", {27'h0, d_out_l, frame_l, done_l, busy_l, in_ready_l}, 32'h01);
    in_valid = 1'b0; shift_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single MSB-first word, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      shift_en = vecs[i].se;
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      @(posedge clk); #1;
      check($sformatf("single_a5_cyc%0d", i), {27'h0, outs_m()}, {27'h0, vecs[i].exp});
    end
    shift_en = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    // Back-to-back words with shift_en tied high.
    words_g[0] = 8'hA5; words_g[1] = 8'h3C;
    stream(2, 1, 0, 22);
    check("b2b_frame_cnt", frame_cnt, 16);
    check("b2b_frame_span", last_frame - first_frame + 1, 16);
    check("b2b_bits", {16'h0, tick_val[15:0]}, 32'h0000A53C);
    check("b2b_done_cnt", done_cyc.size(), 2);
    check("b2b_done_gap", qget(done_cyc, 1) - qget(done_cyc, 0), 8);
    check("b2b_accept2", qget(acc_cyc, 1), 2);

    // Slow tick: shift_en every 4th cycle.
    words_g[0] = 8'h81;
    stream(1, 4, 0, 40);
    check("slow_first_bit_cyc", first_frame, 3);
    check("slow_frame_cnt", frame_cnt, 32);
    check("slow_offtick_changes", viol, 0);
    check("slow_bits", {24'h0, tick_val[7:0]}, 32'h81);
    check("slow_tick_bits", tick_n, 8);
    check("slow_done_cyc", qget(done_cyc, 0), 35);

    // Backpressure: stall shifting, offer three words.
    words_g[0] = 8'h11; words_g[1] = 8'h22; words_g[2] = 8'h33;
    stream(3, 1, 5, 35);
    check("bp_accept0", qget(acc_cyc, 0), 0);
    check("bp_accept1", qget(acc_cyc, 1), 6);
    check("bp_accept2", qget(acc_cyc, 2), 14);
    check("bp_bits", {8'h0, tick_val[23:0]}, 32'h00112233);
    check("bp_tick_bits", tick_n, 24);
    check("bp_done_cnt", done_cyc.size(), 3);
    check("bp_first_frame", first_frame, 5);

    // LSB-first instance.
    lsb_word(8'h01, "lsb_01");
    lsb_word(8'hC2, "lsb_c2");
    shift_en_l = 1'b0;

    // Reset mid-word with a second word buffered.
    shift_en = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk); #1;
    in_data = 8'h0F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rstmid_pre", {30'h0, frame, d_out}, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid_async", {27'h0, outs_m()}, 32'h01);
    seen_frame = 0; seen_done = 0; seen_busy = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (frame) seen_frame++;
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    check("rstmid_no_frame", seen_frame, 0);
    check("rstmid_no_done", seen_done, 0);
    check("rstmid_no_busy", seen_busy, 0);
    check("rstmid_ready", {31'h0, in_ready}, 32'h1);
    shift_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
